maxnet_input_loader: RTL and testbench
======================================

Name: maxnet_input_loader

Overview:
- Upstream feeder for the Maxnet winner-take-all datapath.
- Ingests a serial stream of 32-bit IEEE-754 words over a valid/ready handshake.
- Assembles the 4x4 weight matrix and the 4-element input vector, clamps non-positive/NaN inputs to +0.0, and presents both as parallel buses.
- Pulses start to the controller, then holds its outputs until the datapath reports completion.

Parameters:
- DATA_W, 32, word width (IEEE-754 single).
- N, 4, vector length; weight matrix is N*N.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  loader accepts word this cycle.
- in_data  in  DATA_W  upstream word.
- cfg_load_w  in  1  sampled on the first handshake of a frame; 1 = frame carries W before X.
- dp_done  in  1  datapath finished (is_finished); releases the held vector.
- x_flat  out  N*DATA_W  X[i] at bits [i*DATA_W +: DATA_W].
- w_flat  out  N*N*DATA_W  W[k] at bits [k*DATA_W +: DATA_W], k = row*N+col.
- w_valid  out  1  weights loaded at least once since reset.
- start  out  1  one-cycle pulse: vector ready, begin iteration.
- busy  out  1  frame presented, waiting for dp_done.
- all_zero  out  1  last X frame had no positive element.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, x_flat=0, w_flat=0, w_valid=0, start=0, all_zero=0. Outputs busy=0 and in_ready=0 while in reset.
- Handshake: a word transfers only on clk edge with in_valid & in_ready. in_data is don't-care otherwise. in_valid may drop mid-frame; the count holds.
- in_ready=1 in IDLE, LOAD_W, LOAD_X; 0 in PRESENT, WAIT_DONE.
- cnt: 5-bit word index within the current section.
- IDLE:
  - First handshake: if cfg_load_w=1 or w_valid=0, the word is W[0] -> LOAD_W, cnt=1.
  - Otherwise the word is X[0] -> LOAD_X, cnt=1.
  - all_zero cleared on this handshake.
- LOAD_W: each handshake writes W[cnt], cnt++. On the handshake with cnt=N*N-1: w_valid<=1, cnt<=0 -> LOAD_X. W words stored unmodified.
- LOAD_X: each handshake writes clamp(in_data) to X[cnt], cnt++.
  - clamp gives 0x00000000 if bit31=1 (incl. -0.0) or exponent=0xFF with mantissa!=0 (NaN); else passthrough (+Inf passes).
  - Track any_pos = OR over stored words of |word[30:0].
  - On the handshake with cnt=N-1 -> PRESENT, cnt<=0.
- PRESENT (one cycle):
  - If any_pos=0: all_zero<=1, no start, next state IDLE.
  - Else start=1 this cycle only, next state WAIT_DONE.
- WAIT_DONE: busy=1; x_flat and w_flat frozen. dp_done=1 -> IDLE next cycle (busy=0).
- dp_done is ignored in every state except WAIT_DONE.
- Latency: start is high in the cycle immediately after the final X handshake.
- Reset mid-frame or mid-WAIT_DONE discards all partial data, including w_valid. The next frame must therefore carry W, whatever cfg_load_w is.
- cfg_load_w is ignored except on the first handshake of a frame.

Test Plan:
1. After reset, hold cfg_load_w=0 and send 20 words: W = identity (0x3F800000 on diagonal, 0 elsewhere), then X = 0x3F000000, 0x3E800000, 0x3F400000, 0x3E000000. Expect: forced W load; w_valid=1; start high exactly one cycle after the 20th handshake; x_flat matches; in_ready=0 and busy=1 until dp_done; IDLE one cycle after dp_done.
2. Second frame with cfg_load_w=0 and X = 0x40000000, 0, 0, 0x3F800000. Expect: only 4 words accepted, w_flat unchanged from test 1, start after the 4th handshake.
3. X = 0xBF800000, 0x80000000, 0x7FC00000, 0x3F800000. Expect stored X = 0, 0, 0, 0x3F800000; start asserted; all_zero=0.
4. X = 0xC0000000, 0x00000000, 0x80000000, 0xBF000000. Expect all_zero=1, no start pulse, in_ready=1 two cycles after the last handshake. all_zero clears on the next frame's first handshake.
5. Randomly deassert in_valid mid-W and mid-X, and pulse dp_done during LOAD_X. Expect identical stored data and timing relative to handshakes, with no state change from dp_done.
6. Assert rst_n=0 after 7 W words, release, then send an X-only frame with cfg_load_w=0. Expect w_valid=0 and w_flat=0 after reset, and the first 16 words of that frame treated as W.

Source files
------------

// File: rtl/maxnet_input_loader_if.sv
// maxnet_input_loader_if: upstream word stream with frame-type select
interface maxnet_input_loader_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              cfg_load_w;
  modport master (output in_valid, in_data, cfg_load_w, input in_ready);
  modport slave (input in_valid, in_data, cfg_load_w, output in_ready);
endinterface

// File: rtl/maxnet_input_loader.sv
// maxnet_input_loader: assembles W matrix and clamped X vector for the Maxnet datapath
module maxnet_input_loader #(
  parameter int DATA_W = 32,
  parameter int N      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  maxnet_input_loader_if.slave       up,
  input  logic                       dp_done_i,
  output logic [N*DATA_W-1:0]        x_flat_o,
  output logic [N*N*DATA_W-1:0]      w_flat_o,
  output logic                       w_valid_o,
  output logic                       start_o,
  output logic                       busy_o,
  output logic                       all_zero_o
);
  localparam int WI = $clog2(N*N);
  localparam int XI = $clog2(N);
  localparam logic [4:0] W_LAST = 5'(N*N-1);
  localparam logic [4:0] X_LAST = 5'(N-1);
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, PRESENT, WAIT_DONE} state_t;
  state_t            state_q, state_d;
  logic [4:0]        cnt_q;
  logic              any_pos_q, w_valid_q, all_zero_q;
  logic [DATA_W-1:0] w_q [N*N];
  logic [DATA_W-1:0] x_q [N];
  logic              hs, load_w_sel, w_last, x_last, clamp_zero;
  logic [DATA_W-1:0] cx;
  assign hs         = up.in_valid & up.in_ready;
  assign load_w_sel = up.cfg_load_w | ~w_valid_q;
  assign w_last     = cnt_q == W_LAST;
  assign x_last     = cnt_q == X_LAST;
  assign clamp_zero = up.in_data[31] | (&up.in_data[30:23] & |up.in_data[22:0]);
  assign cx         = clamp_zero ? '0 : up.in_data;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = hs ? (load_w_sel ? LOAD_W : LOAD_X) : IDLE;
      LOAD_W:    state_d = (hs && w_last) ? LOAD_X : LOAD_W;
      LOAD_X:    state_d = (hs && x_last) ? PRESENT : LOAD_X;
      PRESENT:   state_d = any_pos_q ? WAIT_DONE : IDLE;
      WAIT_DONE: state_d = dp_done_i ? IDLE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end
  // outputs decoded from state; in_ready is forced low while reset is held
  always_comb begin
    up.in_ready = rst_n & (state_q == IDLE || state_q == LOAD_W || state_q == LOAD_X);
    start_o     = (state_q == PRESENT) & any_pos_q;
    busy_o      = state_q == WAIT_DONE;
  end
  // word capture, section counter and frame flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      any_pos_q  <= 1'b0;
      w_valid_q  <= 1'b0;
      all_zero_q <= 1'b0;
      for (int i = 0; i < N*N; i++) w_q[i] <= '0;
      for (int i = 0; i < N; i++) x_q[i] <= '0;
    end else begin
      if (hs && state_q == IDLE) begin
        all_zero_q <= 1'b0;
        cnt_q      <= 5'd1;
        if (load_w_sel) begin
          w_q[0]    <= up.in_data;
          any_pos_q <= 1'b0;
        end else begin
          x_q[0]    <= cx;
          any_pos_q <= |cx[30:0];
        end
      end
      if (hs && state_q == LOAD_W) begin
        w_q[cnt_q[WI-1:0]] <= up.in_data;
        cnt_q              <= w_last ? '0 : cnt_q + 5'd1;
        if (w_last) w_valid_q <= 1'b1;
      end
      if (hs && state_q == LOAD_X) begin
        x_q[cnt_q[XI-1:0]] <= cx;
        any_pos_q          <= any_pos_q | (|cx[30:0]);
        cnt_q              <= x_last ? '0 : cnt_q + 5'd1;
      end
      if (state_q == PRESENT && !any_pos_q) all_zero_q <= 1'b1;
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_x
    assign x_flat_o[i*DATA_W +: DATA_W] = x_q[i];
  end
  for (genvar k = 0; k < N*N; k++) begin : g_w
    assign w_flat_o[k*DATA_W +: DATA_W] = w_q[k];
  end
  assign w_valid_o  = w_valid_q;
  assign all_zero_o = all_zero_q;
endmodule

// File: tb/tb_maxnet_input_loader.sv
// tb_maxnet_input_loader: directed frames with a scoreboard checked on start/all_zero
module tb_maxnet_input_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dp_done = 1'b0;
  logic [127:0] x_flat;
  logic [511:0] w_flat;
  logic w_valid, start, busy, all_zero;
  int errors = 0;
  int checks = 0;
  typedef struct packed {logic s; logic [127:0] x; logic [511:0] w;} exp_t;
  exp_t sb[$];
  logic [511:0] exp_w = '0;
  logic prev_start = 1'b0;
  logic prev_az = 1'b0;
  always #5 clk = ~clk;
  maxnet_input_loader_if ifc();
  maxnet_input_loader dut (
    .clk(clk), .rst_n(rst_n), .up(ifc), .dp_done_i(dp_done),
    .x_flat_o(x_flat), .w_flat_o(w_flat), .w_valid_o(w_valid),
    .start_o(start), .busy_o(busy), .all_zero_o(all_zero)
  );
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [31:0] d, input logic cfg, input int gap, input logic dp);
    int n;
    for (int g = 0; g < gap; g++) begin
      ifc.in_valid = 1'b0;
      ifc.in_data = $urandom;
      dp_done = dp;
      @(negedge clk);
    end
    dp_done = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_data = d;
    ifc.cfg_load_w = cfg;
    n = 0;
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", ifc.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask
  task automatic do_frame(input logic cfg, input bit with_w, input logic [31:0] wv[16],
                          input logic [31:0] xv[4], input logic [31:0] xe[4],
                          input bit pos, input bit gaps);
    exp_t e;
    logic [127:0] xf;
    if (with_w) for (int k = 0; k < 16; k++) exp_w[k*32 +: 32] = wv[k];
    for (int i = 0; i < 4; i++) xf[i*32 +: 32] = xe[i];
    e.s = pos;
    e.x = xf;
    e.w = exp_w;
    sb.push_back(e);
    if (with_w)
      for (int k = 0; k < 16; k++) begin
        send(wv[k], k == 0 ? cfg : ~cfg, gaps ? int'($urandom_range(0, 2)) : 0, 1'b0);
        if (k == 0) chk("az_clear", all_zero, 0);
        if (k == 3) chk("no_early_start", start, 0);
      end
    for (int i = 0; i < 4; i++) begin
      send(xv[i], (!with_w && i == 0) ? cfg : ~cfg,
           (gaps && i > 0) ? int'($urandom_range(1, 2)) : 0, gaps);
      if (!with_w && i == 0) chk("az_clear", all_zero, 0);
    end
    chk("start_latency", start, pos);
    if (pos) begin
      chk("w_valid", w_valid, 1);
      chk("all_zero_pos", all_zero, 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("busy_wait", busy, 1);
        chk("ready_wait", ifc.in_ready, 0);
      end
      dp_done = 1'b1;
      @(negedge clk);
      dp_done = 1'b0;
      chk("busy_released", busy, 0);
      chk("ready_released", ifc.in_ready, 1);
    end else begin
      chk("ready_present", ifc.in_ready, 0);
      @(negedge clk);
      chk("ready_after_az", ifc.in_ready, 1);
      chk("all_zero_set", all_zero, 1);
    end
  endtask
  task automatic reset_checks();
    chk("rst_ready", ifc.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_start", start, 0);
    chk("rst_all_zero", all_zero, 0);
    chk("rst_w_flat", w_flat, 0);
    chk("rst_x_flat", x_flat, 0);
  endtask
  // scoreboard monitor: every start pulse or all_zero rise consumes one expected frame
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (start) chk("start_width", prev_start, 0);
      if (start || (all_zero && !prev_az)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: output event with no expected frame");
        end else begin
          e = sb.pop_front();
          chk("sb_kind", start, e.s);
          chk("sb_x", x_flat, e.x);
          chk("sb_w", w_flat, e.w);
        end
      end
    end
    prev_start = rst_n & start;
    prev_az = all_zero;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] wi[16], w5[16], w6[16], x1[4], x2[4], x3[4], e3[4], x4[4], e4[4], x5[4], e5[4], x6[4];
    for (int k = 0; k < 16; k++) begin
      wi[k] = (k % 5 == 0) ? 32'h3F80_0000 : 32'h0;
      w5[k] = 32'h4000_0000 | k;
      w6[k] = 32'h3F80_0000 + k;
    end
    x1 = '{32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000, 32'h3E00_0000};
    x2 = '{32'h4000_0000, 32'h0, 32'h0, 32'h3F80_0000};
    x3 = '{32'hBF80_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h3F80_0000};
    e3 = '{32'h0, 32'h0, 32'h0, 32'h3F80_0000};
    x4 = '{32'hC000_0000, 32'h0, 32'h8000_0000, 32'hBF00_0000};
    e4 = '{32'h0, 32'h0, 32'h0, 32'h0};
    x5 = '{32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0001, 32'h0000_0001};
    e5 = '{32'h7F80_0000, 32'h0, 32'h0, 32'h0000_0001};
    x6 = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    ifc.cfg_load_w = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", ifc.in_ready, 1);
    do_frame(1'b0, 1'b1, wi, x1, x1, 1'b1, 1'b0);
    do_frame(1'b0, 1'b0, wi, x2, x2, 1'b1, 1'b0);
    do_frame(1'b0, 1'b0, wi, x3, e3, 1'b1, 1'b0);
    do_frame(1'b0, 1'b0, wi, x4, e4, 1'b0, 1'b0);
    do_frame(1'b1, 1'b1, w5, x5, e5, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) send(w5[k] ^ 32'hFF, 1'b1, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_checks();
    exp_w = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_frame(1'b0, 1'b1, w6, x6, x6, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
